// File: rtl/dot_product_pkg.sv
// Shared types and sizing helpers for the dot-product job scheduler.
// Default geometry plus the accumulator width rule.
package dot_product_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam int LANES_DEF      = 8;
  localparam int EW_DEF         = 8;
  localparam int MAX_CHUNKS_DEF = 16;

  // Wide enough for MAX_CHUNKS full-scale chunks without overflow.
  function automatic int acc_width(input int lanes, input int ew,
                                   input int mc);
    return 2 * ew + $clog2(lanes * mc);
  endfunction

endpackage

// File: rtl/dot_product_job_sched_if.sv
// Requester/result bundle of the dot-product job scheduler.
// master = requester/consumer side, slave = scheduler side.
interface dot_product_job_sched_if
  import dot_product_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int LANES         = LANES_DEF,
  parameter int ELEMENT_WIDTH = EW_DEF,
  parameter int ACC_WIDTH     = acc_width(LANES_DEF, EW_DEF,
                                          MAX_CHUNKS_DEF)
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int LW  = LANES * ELEMENT_WIDTH;

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    req_last;
  logic [NUM_REQ*LW-1:0] req_a;
  logic [NUM_REQ*LW-1:0] req_b;
  logic                  res_valid;
  logic                  res_ready;
  logic [ACC_WIDTH-1:0]  res_data;
  logic [IDW-1:0]        res_id;
  logic                  res_trunc;
  logic                  busy;

  modport master (
    output req_valid, req_last, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, res_id, res_trunc, busy
  );

  modport slave (
    input  req_valid, req_last, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, res_id, res_trunc, busy
  );

endinterface

// File: rtl/dot_product_chunk.sv
// Combinational LANES-wide unsigned dot product of one chunk.
// Products are widened before summing so no lane truncates.
module dot_product_chunk #(
  parameter  int LANES         = 8,
  parameter  int ELEMENT_WIDTH = 8,
  localparam int LW            = LANES * ELEMENT_WIDTH,
  localparam int DPW           = 2 * ELEMENT_WIDTH + $clog2(LANES)
) (
  input  logic [LW-1:0]  a,
  input  logic [LW-1:0]  b,
  output logic [DPW-1:0] dp
);

  always_comb begin
    dp = '0;
    for (int i = 0; i < LANES; i++) begin
      dp = dp + DPW'(a[i*ELEMENT_WIDTH +: ELEMENT_WIDTH])
              * DPW'(b[i*ELEMENT_WIDTH +: ELEMENT_WIDTH]);
    end
  end

endmodule

// File: rtl/dot_product_job_sched.sv
// Round-robin job scheduler in front of one shared dot-product datapath.
// Jobs are granted whole; one tagged result is returned per job.
module dot_product_job_sched
  import dot_product_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int LANES         = LANES_DEF,
  parameter int ELEMENT_WIDTH = EW_DEF,
  parameter int MAX_CHUNKS    = MAX_CHUNKS_DEF,
  parameter int ACC_WIDTH     = acc_width(LANES, ELEMENT_WIDTH,
                                          MAX_CHUNKS)
) (
  input logic                     clk,
  input logic                     rst,
  dot_product_job_sched_if.slave  bus
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int LW  = LANES * ELEMENT_WIDTH;
  localparam int DPW = 2 * ELEMENT_WIDTH + $clog2(LANES);
  localparam int CW  = $clog2(MAX_CHUNKS + 1);

  state_t               state;
  state_t               state_n;
  logic [IDW-1:0]       rr_ptr;
  logic [IDW-1:0]       grant;
  logic [IDW-1:0]       pick;
  logic [ACC_WIDTH-1:0] acc;
  logic [CW-1:0]        chunk_cnt;
  logic                 trunc;
  logic [LW-1:0]        sel_a;
  logic [LW-1:0]        sel_b;
  logic [DPW-1:0]       chunk_dp;
  logic                 any_valid;
  logic                 beat;
  logic                 at_max;

  assign sel_a = bus.req_a[int'(grant)*LW +: LW];
  assign sel_b = bus.req_b[int'(grant)*LW +: LW];

  dot_product_chunk #(
    .LANES        (LANES),
    .ELEMENT_WIDTH(ELEMENT_WIDTH)
  ) u_chunk (
    .a (sel_a),
    .b (sel_b),
    .dp(chunk_dp)
  );

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    pick      = '0;
    any_valid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any_valid && bus.req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        any_valid = 1'b1;
        pick      = IDW'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  assign beat   = (state == BUSY) && bus.req_valid[grant];
  assign at_max = chunk_cnt == CW'(MAX_CHUNKS - 1);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (any_valid) state_n = BUSY;
      BUSY: if (beat && (bus.req_last[grant] || at_max)) state_n = DONE;
      DONE: if (bus.res_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant     <= '0;
      acc       <= '0;
      chunk_cnt <= '0;
      trunc     <= 1'b0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          if (any_valid) begin
            grant     <= pick;
            acc       <= '0;
            chunk_cnt <= '0;
          end
        end
        BUSY: begin
          if (beat) begin
            acc       <= acc + ACC_WIDTH'(chunk_dp);
            chunk_cnt <= chunk_cnt + 1'b1;
            trunc     <= !bus.req_last[grant];
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            rr_ptr <= (grant == IDW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (state == BUSY) bus.req_ready[grant] = 1'b1;
    bus.res_valid = state == DONE;
    bus.res_data  = (state == DONE) ? acc : '0;
    bus.res_id    = (state == DONE) ? grant : '0;
    bus.res_trunc = (state == DONE) && trunc;
    bus.busy      = state != IDLE;
  end

endmodule

// File: tb/tb_dot_product_job_sched.sv
// Bench for dot_product_job_sched: directed jobs plus random traffic,
// checked every cycle against a job-level model of the results.
module tb_dot_product_job_sched;
  import dot_product_pkg::*;

  localparam int NR = 2;
  localparam int LN = 8;
  localparam int EW = 8;
  localparam int MC = 16;
  localparam int AW = acc_width(LN, EW, MC);
  localparam int LW = LN * EW;

  typedef struct {
    logic [LW-1:0] a;
    logic [LW-1:0] b;
    logic          last;
    int            gap;
  } chunk_t;

  typedef struct {
    longint data;
    int     id;
    logic   trunc;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  dot_product_job_sched_if #(
    .NUM_REQ(NR), .LANES(LN), .ELEMENT_WIDTH(EW), .ACC_WIDTH(AW)
  ) bus ();

  dot_product_job_sched #(
    .NUM_REQ(NR), .LANES(LN), .ELEMENT_WIDTH(EW),
    .MAX_CHUNKS(MC), .ACC_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  chunk_t chq[NR][$];
  bit     pres[NR];
  int     gapc[NR];
  int     beats[NR];
  res_t   log_q[$];
  bit     rr_mode = 1'b0;
  int     n_checks = 0;
  int     n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic longint dot(input logic [LW-1:0] a,
                                 input logic [LW-1:0] b);
    longint s = 0;
    for (int i = 0; i < LN; i++)
      s += longint'(a[i*EW +: EW]) * longint'(b[i*EW +: EW]);
    return s;
  endfunction

  function automatic logic [LW-1:0] rep(input logic [EW-1:0] v);
    return {LN{v}};
  endfunction

  function automatic logic [LW-1:0] rnd_vec();
    logic [LW-1:0] v;
    for (int i = 0; i < LN; i++) v[i*EW +: EW] = EW'($urandom);
    return v;
  endfunction

  // Job-level model: accumulate accepted beats, close a job on last
  // or on the MC-th beat, then expect the result from the next cycle
  // until it is taken.
  longint mac[NR];
  int     mcnt[NR];
  bit     pend = 1'b0;
  res_t   pr;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 1'b0;
        for (int r = 0; r < NR; r++) begin
          mac[r]  = 0;
          mcnt[r] = 0;
        end
      end else begin
        chk("res_valid", 64'(bus.res_valid), 64'(pend));
        chk("ready_onehot", 64'($countones(bus.req_ready) <= 1), 64'd1);
        if (pend) begin
          chk("res_data", 64'(bus.res_data), pr.data);
          chk("res_id", 64'(bus.res_id), 64'(pr.id));
          chk("res_trunc", 64'(bus.res_trunc), 64'(pr.trunc));
          chk("ready_in_done", 64'(bus.req_ready), 64'd0);
          chk("busy_in_done", 64'(bus.busy), 64'd1);
          if (bus.res_valid && bus.res_ready) begin
            log_q.push_back('{data: 64'(bus.res_data),
                              id: int'(bus.res_id),
                              trunc: bus.res_trunc});
            pend = 1'b0;
          end
        end
        for (int r = 0; r < NR; r++) begin
          if (bus.req_valid[r] && bus.req_ready[r]) begin
            mac[r] += dot(bus.req_a[r*LW +: LW], bus.req_b[r*LW +: LW]);
            mcnt[r]++;
            if (bus.req_last[r] || mcnt[r] == MC) begin
              pend     = 1'b1;
              pr.data  = mac[r];
              pr.id    = r;
              pr.trunc = !bus.req_last[r];
              mac[r]   = 0;
              mcnt[r]  = 0;
            end
          end
        end
      end
    end
  end

  task automatic push(input int r, input logic [LW-1:0] a,
                      input logic [LW-1:0] b, input logic last,
                      input int gap);
    if (chq[r].size() == 0 && !pres[r]) gapc[r] = gap;
    chq[r].push_back('{a: a, b: b, last: last, gap: gap});
  endtask

  task automatic drive();
    for (int r = 0; r < NR; r++) begin
      bus.req_valid[r] = pres[r];
      bus.req_last[r]  = pres[r] ? chq[r][0].last : 1'b0;
      bus.req_a[r*LW +: LW] = pres[r] ? chq[r][0].a : '0;
      bus.req_b[r*LW +: LW] = pres[r] ? chq[r][0].b : '0;
    end
  endtask

  task automatic step();
    logic [NR-1:0] took;
    @(negedge clk);
    took = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
    for (int r = 0; r < NR; r++) begin
      if (took[r]) begin
        beats[r]++;
        void'(chq[r].pop_front());
        pres[r] = 1'b0;
        if (chq[r].size() > 0) gapc[r] = chq[r][0].gap;
      end
      if (!pres[r] && chq[r].size() > 0) begin
        if (gapc[r] > 0) gapc[r]--;
        else pres[r] = 1'b1;
      end
    end
    drive();
    if (rr_mode) bus.res_ready = $urandom_range(0, 9) < 7;
  endtask

  function automatic bit all_empty();
    for (int r = 0; r < NR; r++)
      if (chq[r].size() != 0 || pres[r]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_done(input string nm, input int maxc);
    int c = 0;
    do begin
      step();
      c++;
    end while (!(all_empty() && !bus.busy) && c < maxc);
    if (c >= maxc) chk({nm, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic chk_res(input string nm, input int idx,
                         input longint d, input int id, input logic t);
    if (idx < log_q.size()) begin
      chk({nm, "_data"}, 64'(log_q[idx].data), 64'(d));
      chk({nm, "_id"}, 64'(log_q[idx].id), 64'(id));
      chk({nm, "_trunc"}, 64'(log_q[idx].trunc), 64'(t));
    end else begin
      chk({nm, "_missing"}, 64'd0, 64'd1);
    end
  endtask

  task automatic zero_chk(input string p);
    chk({p, "_req_ready"}, 64'(bus.req_ready), 64'd0);
    chk({p, "_res_valid"}, 64'(bus.res_valid), 64'd0);
    chk({p, "_res_data"}, 64'(bus.res_data), 64'd0);
    chk({p, "_res_id"}, 64'(bus.res_id), 64'd0);
    chk({p, "_res_trunc"}, 64'(bus.res_trunc), 64'd0);
    chk({p, "_busy"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int base;
    int exp_n;
    int b0;
    int c;
    int start;

    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    zero_chk("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.res_ready = 1'b1;

    // Single 3-chunk job: 3 * 8 * (1*2) = 48
    base = log_q.size();
    for (int k = 0; k < 3; k++) push(0, rep(8'd1), rep(8'd2), k == 2, 0);
    run_done("t1", 100);
    chk("t1_count", 64'(log_q.size() - base), 64'd1);
    chk_res("t1", base, 48, 0, 1'b0);

    // Full scale: 16 * 8 * 255 * 255 = 8323200
    base = log_q.size();
    for (int k = 0; k < 16; k++)
      push(0, rep(8'hff), rep(8'hff), k == 15, 0);
    run_done("t2", 200);
    chk_res("t2", base, 8323200, 0, 1'b0);

    // 18 chunks of ones: 16 forced (128, trunc) then 2 (16)
    base = log_q.size();
    for (int k = 0; k < 18; k++) push(1, rep(8'd1), rep(8'd1), k == 17, 0);
    run_done("t3", 200);
    chk("t3_count", 64'(log_q.size() - base), 64'd2);
    chk_res("t3a", base, 128, 1, 1'b1);
    chk_res("t3b", base + 1, 16, 1, 1'b0);

    // Both requesters stream 1-chunk jobs: grants alternate 0,1,0,1
    base = log_q.size();
    for (int k = 0; k < 2; k++) begin
      push(0, rep(8'd1), rep(8'd1), 1'b1, 0);
      push(1, rep(8'd2), rep(8'd1), 1'b1, 0);
    end
    run_done("t4", 100);
    chk_res("t4_0", base, 8, 0, 1'b0);
    chk_res("t4_1", base + 1, 16, 1, 1'b0);
    chk_res("t4_2", base + 2, 8, 0, 1'b0);
    chk_res("t4_3", base + 3, 16, 1, 1'b0);

    // Back-pressure with the other requester waiting
    base = log_q.size();
    bus.res_ready = 1'b0;
    push(0, rep(8'd2), rep(8'd3), 1'b1, 0);
    push(1, rep(8'd1), rep(8'd1), 1'b1, 0);
    c = 0;
    while (!bus.res_valid && c < 20) begin
      step();
      c++;
    end
    chk("t5_reached_done", 64'(bus.res_valid), 64'd1);
    b0 = beats[0] + beats[1];
    repeat (5) step();
    chk("t5_no_beats", 64'(beats[0] + beats[1] - b0), 64'd0);
    chk("t5_hold_valid", 64'(bus.res_valid), 64'd1);
    chk("t5_hold_data", 64'(bus.res_data), 64'd48);
    chk("t5_ready_zero", 64'(bus.req_ready), 64'd0);
    bus.res_ready = 1'b1;
    run_done("t5", 100);
    chk("t5_count", 64'(log_q.size() - base), 64'd2);
    chk_res("t5_0", base, 48, 0, 1'b0);
    chk_res("t5_1", base + 1, 8, 1, 1'b0);

    // Random jobs with gaps and random result back-pressure
    base  = log_q.size();
    exp_n = 0;
    for (int r = 0; r < NR; r++) begin
      for (int j = 0; j < 25; j++) begin
        int len;
        len = $urandom_range(1, 20);
        exp_n += (len + MC - 1) / MC;
        for (int k = 0; k < len; k++)
          push(r, rnd_vec(), rnd_vec(), k == len - 1, $urandom_range(0, 2));
      end
    end
    rr_mode = 1'b1;
    run_done("rand", 30000);
    rr_mode = 1'b0;
    bus.res_ready = 1'b1;
    chk("rand_count", 64'(log_q.size() - base), 64'(exp_n));

    // Reset after 2 of 4 chunks discards the job
    base  = log_q.size();
    start = beats[0];
    for (int k = 0; k < 4; k++) push(0, rep(8'd1), rep(8'd1), k == 3, 0);
    c = 0;
    while (beats[0] - start < 2 && c < 50) begin
      step();
      c++;
    end
    chk("t6_two_beats", 64'(beats[0] - start), 64'd2);
    rst = 1'b1;
    for (int r = 0; r < NR; r++) begin
      chq[r].delete();
      pres[r] = 1'b0;
    end
    drive();
    @(posedge clk);
    @(negedge clk);
    zero_chk("t6_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    push(0, rep(8'd3), rep(8'd3), 1'b1, 0);
    run_done("t6", 100);
    chk("t6_count", 64'(log_q.size() - base), 64'd1);
    chk_res("t6", base, 72, 0, 1'b0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
